axi4_lite_sram_slave: RTL
=========================

Name: axi4_lite_sram_slave

Overview:
AXI4-Lite slave memory that terminates the core's AXI4-Lite master port (IFU/LSU side) and serves reads and writes from an internal word array. Read and write channels are independent, each with a programmable response latency, to model realistic SRAM delay. Out-of-range accesses complete with DECERR. Sits directly downstream of the AXI4-Lite master; its five channels connect one-to-one to the master's ar/r/aw/w/b ports.

Parameters:
ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH)
DATA_WIDTH, 32, data width (matches `DATA_WIDTH)
MASK_WIDTH, 4, write-strobe width, DATA_WIDTH/8
RESP_WIDTH, 2, response width
BASE_ADDR, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 1024, number of DATA_WIDTH words; power of two
RD_LATENCY, 1, cycles from AR handshake to first rvalid; must be >=1
WR_LATENCY, 1, cycles from last of AW/W handshake to bvalid; must be >=1

Ports:
iClock  in  1  clock
iReset  in  1  synchronous active-high reset
pAXI4_ar_valid  in  1  read address valid
pAXI4_ar_ready  out  1  read address ready
pAXI4_ar_bits_addr  in  ADDR_WIDTH  read byte address
pAXI4_r_valid  out  1  read data valid
pAXI4_r_ready  in  1  read data ready
pAXI4_r_bits_data  out  DATA_WIDTH  read data
pAXI4_r_bits_resp  out  RESP_WIDTH  read response
pAXI4_aw_valid  in  1  write address valid
pAXI4_aw_ready  out  1  write address ready
pAXI4_aw_bits_addr  in  ADDR_WIDTH  write byte address
pAXI4_w_valid  in  1  write data valid
pAXI4_w_ready  out  1  write data ready
pAXI4_w_bits_data  in  DATA_WIDTH  write data
pAXI4_w_bits_strb  in  MASK_WIDTH  byte strobes
pAXI4_b_valid  out  1  write response valid
pAXI4_b_ready  in  1  write response ready
pAXI4_b_bits_resp  out  RESP_WIDTH  write response

Behaviour:
- Reset: iClock and iReset; reset is synchronous, active-high. Reset values: ar_ready=1, aw_ready=1, w_ready=1, r_valid=0, r_data=0, r_resp=OKAY, b_valid=0, b_resp=OKAY. Both FSMs return to IDLE. Latency counters clear. Captured AW/W flags clear. Memory contents are not cleared.
- Reset mid-transaction: any pending read or write is dropped with no response. A write not yet committed is not performed.
- Address decode: index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored. In range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*4.
- Read FSM:
  - RD_IDLE: ar_ready=1. On ar_valid&&ar_ready, latch the address. Go to RD_RESP if RD_LATENCY==1, else go to RD_WAIT with counter = RD_LATENCY-1.
  - RD_WAIT: ar_ready=0. Decrement each cycle; at 1, go to RD_RESP.
  - Data and resp are sampled on entry to RD_RESP. In range gives OKAY and mem[index]; out of range gives DECERR (2'b11) and data 0.
  - RD_RESP: r_valid=1. r_data/r_resp hold stable until r_ready. On r_valid&&r_ready, go to RD_IDLE; r_data holds its last value. No back-to-back AR accept in the handshake cycle.
- Write FSM:
  - WR_IDLE: aw_ready=!aw_captured, w_ready=!w_captured. AW and W are accepted in either order or in the same cycle, and each is latched.
  - Once both are captured, go to WR_WAIT (or WR_RESP directly if WR_LATENCY==1) with counter = WR_LATENCY-1.
  - While in WR_WAIT or WR_RESP, aw_ready=w_ready=0.
  - Commit happens on entry to WR_RESP. If in range, byte i of mem[index] is written iff strb[i]. Out of range writes nothing and gives b_resp=DECERR; otherwise OKAY.
  - WR_RESP: b_valid=1 until b_ready. On handshake, clear the captured flags and go to WR_IDLE.
- Read/write collision: if the read sample and the write commit fall in the same cycle on the same word, the read returns the pre-write data. Reads sampled in any later cycle see the new data.
- Latency: with RD_LATENCY=N, an AR handshake at cycle T gives r_valid high from cycle T+N. The same rule applies to writes, measured from the cycle both AW and W are captured.
- Back-pressure: r_ready/b_ready held low keeps r_valid/b_valid and their payload stable indefinitely.

Decomposition:
- Shared constants in Config.v: ADDR/DATA/MASK/RESP widths, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- FSM state encodings stay local parameters.
- One sub-module: axi4_lite_lat_cnt, a loadable down-counter with load, value and done outputs. It is instantiated once per channel.

Test Plan:
- Reset, then write 0xDEADBEEF with strb 4'hF to 0x80000010, then read 0x80000010 -> b_resp=00, r_data=0xDEADBEEF, r_resp=00.
- Write 0x11223344 with strb 4'b0101 over 0xAAAAAAAA at 0x80000020, then read -> r_data=0xAA22AA44.
- With RD_LATENCY=3, AR handshake at cycle 10 -> r_valid first high at cycle 13. Hold r_ready=0 for 5 cycles -> r_valid and r_data stable throughout.
- W presented 2 cycles before AW, then AW -> w_ready drops after the W handshake; b_valid rises WR_LATENCY cycles after the AW handshake.
- Read 0x7FFFFFFC and write 0x80001000 (DEPTH=1024) -> r_resp=11 with r_data=0, b_resp=11, memory unchanged.
- Assert iReset while in RD_WAIT with a pending write captured -> next cycle r_valid=0, b_valid=0, ar_ready=aw_ready=w_ready=1, and the pending write is not committed.

Source files
------------

// File: rtl/axi4_lite_sram_slave_pkg.sv
// Shared constants for the AXI4-Lite SRAM slave: bus widths, response codes
// and the default memory window.
package axi4_lite_sram_slave_pkg;

  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiMaskWidth = AxiDataWidth / 8;
  localparam int unsigned AxiRespWidth = 2;

  localparam logic [AxiRespWidth-1:0] RespOkay   = 2'b00;
  localparam logic [AxiRespWidth-1:0] RespSlverr = 2'b10;
  localparam logic [AxiRespWidth-1:0] RespDecerr = 2'b11;

  localparam logic [AxiAddrWidth-1:0] SramBaseAddr   = 32'h8000_0000;
  localparam int unsigned             SramDepthWords = 1024;

endpackage

// File: rtl/axi4_lite_lat_cnt.sv
// Loadable down-counter used to time a channel's response latency.
//   iClock, iReset : clock, synchronous active-high reset
//   load_i         : load load_val_i this cycle (takes priority)
//   load_val_i     : value to load
//   value_o        : current count
//   done_o         : count is at 1 (or already 0), i.e. the wait ends this cycle
module axi4_lite_lat_cnt
  import axi4_lite_sram_slave_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] value_o,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign done_o  = (cnt_q <= Width'(1));

endmodule

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave backed by an internal word array, with independent read and
// write channels and programmable response latency on each.
//   iClock, iReset : clock, synchronous active-high reset
//   pAXI4_ar_*     : read address channel (valid/ready/addr)
//   pAXI4_r_*      : read data channel (valid/ready/data/resp)
//   pAXI4_aw_*     : write address channel (valid/ready/addr)
//   pAXI4_w_*      : write data channel (valid/ready/data/strb)
//   pAXI4_b_*      : write response channel (valid/ready/resp)
// Accesses outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*bytes) answer DECERR.
module axi4_lite_sram_slave
  import axi4_lite_sram_slave_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = AxiAddrWidth,
  parameter int unsigned           DATA_WIDTH  = AxiDataWidth,
  parameter int unsigned           MASK_WIDTH  = AxiMaskWidth,
  parameter int unsigned           RESP_WIDTH  = AxiRespWidth,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(SramBaseAddr),
  parameter int unsigned           DEPTH_WORDS = SramDepthWords,
  parameter int unsigned           RD_LATENCY  = 1,
  parameter int unsigned           WR_LATENCY  = 1
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  pAXI4_ar_valid,
  output logic                  pAXI4_ar_ready,
  input  logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,
  output logic                  pAXI4_r_valid,
  input  logic                  pAXI4_r_ready,
  output logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
  output logic [RESP_WIDTH-1:0] pAXI4_r_bits_resp,
  input  logic                  pAXI4_aw_valid,
  output logic                  pAXI4_aw_ready,
  input  logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,
  input  logic                  pAXI4_w_valid,
  output logic                  pAXI4_w_ready,
  input  logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
  input  logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb,
  output logic                  pAXI4_b_valid,
  input  logic                  pAXI4_b_ready,
  output logic [RESP_WIDTH-1:0] pAXI4_b_bits_resp
);

  localparam int unsigned ByteOff    = $clog2(MASK_WIDTH);
  localparam int unsigned IdxWidth   = $clog2(DEPTH_WORDS);
  localparam int unsigned RdCntWidth = $clog2(RD_LATENCY + 1);
  localparam int unsigned WrCntWidth = $clog2(WR_LATENCY + 1);

  typedef enum logic [1:0] {RdIdle, RdWait, RdResp} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrWait, WrResp} wr_state_e;

  // Offset is computed modulo 2^ADDR_WIDTH, so the upper-bound test is done on
  // the high offset bits to stay correct when the window ends at the top of
  // the address space.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> (ByteOff + IdxWidth)) == '0);
  endfunction

  function automatic logic [IdxWidth-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return off[ByteOff +: IdxWidth];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_eff;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [RESP_WIDTH-1:0] r_resp_q;
  logic                  ar_hs, r_hs, rd_enter_resp;
  logic                  rd_cnt_load, rd_cnt_done, rd_cnt_busy;
  logic [RdCntWidth-1:0] rd_cnt_value;

  assign ar_hs         = pAXI4_ar_valid & pAXI4_ar_ready;
  assign r_hs          = pAXI4_r_valid & pAXI4_r_ready;
  assign rd_cnt_load   = ar_hs;
  assign rd_cnt_busy   = (rd_cnt_value != '0);
  assign rd_enter_resp = (rd_state_d == RdResp) && (rd_state_q != RdResp);
  // With unit latency the sample happens in the accept cycle, before the latch.
  assign rd_addr_eff   = (rd_state_q == RdIdle) ? pAXI4_ar_bits_addr : rd_addr_q;

  axi4_lite_lat_cnt #(
    .Width (RdCntWidth)
  ) u_rd_lat_cnt (
    .iClock     (iClock),
    .iReset     (iReset),
    .load_i     (rd_cnt_load),
    .load_val_i (RdCntWidth'(RD_LATENCY - 1)),
    .value_o    (rd_cnt_value),
    .done_o     (rd_cnt_done)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      rd_state_q <= RdIdle;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RdIdle: if (ar_hs) rd_state_d = (RD_LATENCY == 1) ? RdResp : RdWait;
      // An empty counter also exits so a stray zero can never stall the channel.
      RdWait: if (rd_cnt_done || !rd_cnt_busy) rd_state_d = RdResp;
      RdResp: if (r_hs) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    pAXI4_ar_ready    = (rd_state_q == RdIdle);
    pAXI4_r_valid     = (rd_state_q == RdResp);
    pAXI4_r_bits_data = r_data_q;
    pAXI4_r_bits_resp = r_resp_q;
  end

  // Sampled on entry to the response state and held until the next sample.
  // Reading mem with a non-blocking sample yields pre-write data when a write
  // commits on the same edge.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rd_addr_q <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_WIDTH'(RespOkay);
    end else begin
      if (ar_hs) begin
        rd_addr_q <= pAXI4_ar_bits_addr;
      end
      if (rd_enter_resp) begin
        if (addr_in_range(rd_addr_eff)) begin
          r_data_q <= mem[addr_index(rd_addr_eff)];
          r_resp_q <= RESP_WIDTH'(RespOkay);
        end else begin
          r_data_q <= '0;
          r_resp_q <= RESP_WIDTH'(RespDecerr);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_cap_q, w_cap_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_eff;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_eff;
  logic [MASK_WIDTH-1:0] wr_strb_q, wr_strb_eff;
  logic [RESP_WIDTH-1:0] b_resp_q;
  logic                  aw_hs, w_hs, b_hs, aw_have, w_have;
  logic                  wr_enter_resp, wr_in_range, wr_commit;
  logic                  wr_cnt_load, wr_cnt_done, wr_cnt_busy;
  logic [WrCntWidth-1:0] wr_cnt_value;

  assign aw_hs   = pAXI4_aw_valid & pAXI4_aw_ready;
  assign w_hs    = pAXI4_w_valid & pAXI4_w_ready;
  assign b_hs    = pAXI4_b_valid & pAXI4_b_ready;
  assign aw_have = aw_cap_q | aw_hs;
  assign w_have  = w_cap_q | w_hs;

  // The final handshake may coincide with the commit edge, so the payload is
  // taken from the bus for whichever half has not been latched yet.
  assign wr_addr_eff = aw_cap_q ? wr_addr_q : pAXI4_aw_bits_addr;
  assign wr_data_eff = w_cap_q ? wr_data_q : pAXI4_w_bits_data;
  assign wr_strb_eff = w_cap_q ? wr_strb_q : pAXI4_w_bits_strb;

  assign wr_cnt_load   = (wr_state_q == WrIdle) && aw_have && w_have;
  assign wr_cnt_busy   = (wr_cnt_value != '0);
  assign wr_enter_resp = (wr_state_d == WrResp) && (wr_state_q != WrResp);
  assign wr_in_range   = addr_in_range(wr_addr_eff);
  assign wr_commit     = wr_enter_resp && wr_in_range && !iReset;

  axi4_lite_lat_cnt #(
    .Width (WrCntWidth)
  ) u_wr_lat_cnt (
    .iClock     (iClock),
    .iReset     (iReset),
    .load_i     (wr_cnt_load),
    .load_val_i (WrCntWidth'(WR_LATENCY - 1)),
    .value_o    (wr_cnt_value),
    .done_o     (wr_cnt_done)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      wr_state_q <= WrIdle;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WrIdle: if (aw_have && w_have) wr_state_d = (WR_LATENCY == 1) ? WrResp : WrWait;
      WrWait: if (wr_cnt_done || !wr_cnt_busy) wr_state_d = WrResp;
      WrResp: if (b_hs) wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    pAXI4_aw_ready    = (wr_state_q == WrIdle) && !aw_cap_q;
    pAXI4_w_ready     = (wr_state_q == WrIdle) && !w_cap_q;
    pAXI4_b_valid     = (wr_state_q == WrResp);
    pAXI4_b_bits_resp = b_resp_q;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      b_resp_q  <= RESP_WIDTH'(RespOkay);
    end else begin
      if (b_hs) begin
        aw_cap_q <= 1'b0;
        w_cap_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_cap_q <= 1'b1;
        if (w_hs)  w_cap_q  <= 1'b1;
      end
      if (aw_hs) begin
        wr_addr_q <= pAXI4_aw_bits_addr;
      end
      if (w_hs) begin
        wr_data_q <= pAXI4_w_bits_data;
        wr_strb_q <= pAXI4_w_bits_strb;
      end
      if (wr_enter_resp) begin
        b_resp_q <= wr_in_range ? RESP_WIDTH'(RespOkay) : RESP_WIDTH'(RespDecerr);
      end
    end
  end

  // Memory contents survive reset; only the commit is gated by it.
  always_ff @(posedge iClock) begin
    if (wr_commit) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wr_strb_eff[i]) begin
          mem[addr_index(wr_addr_eff)][8*i +: 8] <= wr_data_eff[8*i +: 8];
        end
      end
    end
  end

endmodule
